// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - UART receive front end: sync, start/data/stop sampling, one-entry holding register (macro UART_RX_PARITY_EN adds even parity)
module uart_rx_frontend #(
  parameter int BIT_CYCLES  = 868,
  parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rxData,
  output logic       rxValid,
  input  logic       rxReady,
  output logic       frameError,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parityError,
`endif
  output logic       busy
);

  localparam logic [15:0] HALF_LAST = 16'(HALF_CYCLES - 1);
  localparam logic [15:0] BIT_LAST  = 16'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  logic        rxMeta;
  logic        rxS;
  state_t      state;
  logic [15:0] cycleCnt;
  logic [2:0]  bitCnt;
  logic [7:0]  shiftReg;
  logic        byteDone;
`ifdef UART_RX_PARITY_EN
  logic        parityBad;
`endif

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxS    <= rxMeta;
    end
  end

  // Frame FSM: counter restarts on every state entry, sampling happens at its terminal count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cycleCnt   <= 16'd0;
      bitCnt     <= 3'd0;
      shiftReg   <= 8'h00;
      byteDone   <= 1'b0;
      frameError <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBad   <= 1'b0;
      parityError <= 1'b0;
`endif
    end else begin
      byteDone   <= 1'b0;
      frameError <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityError <= 1'b0;
`endif
      cycleCnt <= cycleCnt + 16'd1;
      case (state)
        IDLE: begin
          cycleCnt <= 16'd0;
          if (!rxS) state <= START;
        end
        START: begin
          if (cycleCnt == HALF_LAST) begin
            cycleCnt <= 16'd0;
            if (!rxS) begin
              state  <= DATA;
              bitCnt <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (cycleCnt == BIT_LAST) begin
            cycleCnt <= 16'd0;
            shiftReg <= {rxS, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cycleCnt == BIT_LAST) begin
            cycleCnt  <= 16'd0;
            parityBad <= (^shiftReg) ^ rxS;
            state     <= STOP;
          end
        end
`endif
        STOP: begin
          if (cycleCnt == BIT_LAST) begin
            cycleCnt <= 16'd0;
            if (!rxS) begin
              frameError <= 1'b1;
              state      <= WAIT_HIGH;
            end else begin
`ifdef UART_RX_PARITY_EN
              if (parityBad) parityError <= 1'b1;
              else           byteDone    <= 1'b1;
`else
              byteDone <= 1'b1;
`endif
              state <= IDLE;
            end
          end
        end
        WAIT_HIGH: begin
          cycleCnt <= 16'd0;
          if (rxS) state <= IDLE;
        end
        default: begin
          cycleCnt <= 16'd0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Holding register: load when empty or draining, otherwise drop the new byte and flag overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxData  <= 8'h00;
      rxValid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (byteDone) begin
        if (!rxValid || rxReady) begin
          rxData  <= shiftReg;
          rxValid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rxValid && rxReady) begin
        rxValid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb/tb_uart_rx_frontend.sv - directed bench for uart_rx_frontend with per-cycle model compare
module tb_uart_rx_frontend;

  localparam int BIT  = 16;
  localparam int HALF = BIT / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
  localparam int LAT   = 171;
`else
  localparam int PBITS = 0;
  localparam int LAT   = 155;
`endif
  localparam int MAXC   = 8192;
  localparam int EV_NONE = 0;
  localparam int EV_DEL  = 1;
  localparam int EV_FE   = 2;
  localparam int EV_PE   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rxReady = 1'b0;
  logic [7:0] rxData;
  logic       rxValid;
  logic       frameError;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parityError;
`endif

  uart_rx_frontend #(.BIT_CYCLES(BIT), .HALF_CYCLES(HALF)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .rxData(rxData),
    .rxValid(rxValid),
    .rxReady(rxReady),
    .frameError(frameError),
    .overrun(overrun),
`ifdef UART_RX_PARITY_EN
    .parityError(parityError),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  bit         busyMap [MAXC];
  int         evKind  [MAXC];
  logic [7:0] evData  [MAXC];
  logic       mValid = 1'b0;
  logic [7:0] mData = 8'h00;
  logic       mFe = 1'b0;
  logic       mOv = 1'b0;
  logic       mPe = 1'b0;
  logic       mBusy = 1'b0;
  int         feCount = 0;
  int         ovCount = 0;
  int         peCount = 0;
  int         riseCyc = -1;
  bit         prevValid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: frame completions are scheduled by the sender; here only the holding-register rules live
  always @(posedge clk) begin
    cyc = cyc + 1;
    mFe = 1'b0;
    mOv = 1'b0;
    mPe = 1'b0;
    if (reset || cyc >= MAXC) begin
      mValid = 1'b0;
      mData  = 8'h00;
      mBusy  = 1'b0;
    end else begin
      mBusy = busyMap[cyc];
      if (evKind[cyc] == EV_FE) mFe = 1'b1;
      if (evKind[cyc] == EV_PE) mPe = 1'b1;
      if (evKind[cyc] == EV_DEL) begin
        if (!mValid || rxReady) begin
          mData  = evData[cyc];
          mValid = 1'b1;
        end else begin
          mOv = 1'b1;
        end
      end else if (mValid && rxReady) begin
        mValid = 1'b0;
      end
    end
  end

  // Per-cycle compare away from the active edge
  always @(negedge clk) begin
    chk("rxValid", 32'(rxValid), 32'(mValid));
    chk("rxData", 32'(rxData), 32'(mData));
    chk("frameError", 32'(frameError), 32'(mFe));
    chk("overrun", 32'(overrun), 32'(mOv));
    chk("busy", 32'(busy), 32'(mBusy));
`ifdef UART_RX_PARITY_EN
    chk("parityError", 32'(parityError), 32'(mPe));
    if (parityError === 1'b1) peCount++;
`endif
    if (frameError === 1'b1) feCount++;
    if (overrun === 1'b1) ovCount++;
    if (rxValid === 1'b1 && !prevValid) riseCyc = cyc;
    prevValid = (rxValid === 1'b1);
  end

  // c is the first clock edge that captures the start-bit falling edge
  task automatic sendFrame(input logic [7:0] d, input bit parFlip, input bit stopBit,
                           input int holdLow, output int c);
    int stopAt;
    int relAt;
    c = cyc + 1;
    stopAt = c + 2 + HALF + BIT * (9 + PBITS);
    for (int n = c + 2; n < stopAt; n++) busyMap[n] = 1'b1;
    if (!stopBit) begin
      relAt = c - 1 + BIT * (10 + PBITS) + holdLow;
      for (int n = stopAt; n <= relAt + 2; n++) busyMap[n] = 1'b1;
      evKind[stopAt] = EV_FE;
    end else if (parFlip) begin
      evKind[stopAt] = EV_PE;
    end else begin
      evKind[stopAt + 1] = EV_DEL;
      evData[stopAt + 1] = d;
    end
    rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(BIT);
    end
    if (PBITS == 1) begin
      rx = (^d) ^ parFlip;
      tick(BIT);
    end
    rx = stopBit;
    tick(BIT);
    if (!stopBit) begin
      tick(holdLow);
      rx = 1'b1;
    end
  endtask

  task automatic drain();
    rxReady = 1'b1;
    tick(1);
    rxReady = 1'b0;
  endtask

  initial begin
    int c;
    int c2;
    int fe0;
    int ov0;
    int pe0;

    tick(2);
    chk("reset_rxValid", 32'(rxValid), 32'd0);
    chk("reset_rxData", 32'(rxData), 32'h00);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_flags", 32'({frameError, overrun}), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(5);

    // 8'hA5, consumer not ready
    sendFrame(8'hA5, 1'b0, 1'b1, 0, c);
    tick(3);
    chk("a5_latency", 32'(riseCyc - c), 32'(LAT));
    chk("a5_rxData", 32'(rxData), 32'hA5);
    chk("a5_rxValid", 32'(rxValid), 32'd1);
    chk("a5_noflags", 32'(feCount + ovCount), 32'd0);
    drain();
    tick(10);

    // Short low glitch aborts in START
    c = cyc + 1;
    for (int n = c + 2; n <= c + 9; n++) busyMap[n] = 1'b1;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(20);
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_rxValid", 32'(rxValid), 32'd0);
    chk("glitch_noflags", 32'(feCount + ovCount), 32'd0);

    // Bad stop bit followed by a break
    fe0 = feCount;
    sendFrame(8'h3C, 1'b0, 1'b0, 40, c);
    chk("fe_busy_held", 32'(busy), 32'd1);
    tick(5);
    chk("fe_busy_released", 32'(busy), 32'd0);
    chk("fe_pulse_count", 32'(feCount - fe0), 32'd1);
    chk("fe_rxValid", 32'(rxValid), 32'd0);
    tick(10);

    // Back-to-back bytes, consumer stalled
    ov0 = ovCount;
    sendFrame(8'h11, 1'b0, 1'b1, 0, c);
    sendFrame(8'h22, 1'b0, 1'b1, 0, c2);
    tick(5);
    chk("ov_rxData", 32'(rxData), 32'h11);
    chk("ov_pulse_count", 32'(ovCount - ov0), 32'd1);
    drain();
    tick(10);

    // Same, but the consumer drains in the delivery cycle
    ov0 = ovCount;
    sendFrame(8'h11, 1'b0, 1'b1, 0, c);
    fork
      sendFrame(8'h22, 1'b0, 1'b1, 0, c2);
      begin
        tick(LAT);
        rxReady = 1'b1;
        tick(1);
        rxReady = 1'b0;
      end
    join
    tick(5);
    chk("drain_rxData", 32'(rxData), 32'h22);
    chk("drain_rxValid", 32'(rxValid), 32'd1);
    chk("drain_no_overrun", 32'(ovCount - ov0), 32'd0);
    drain();
    tick(10);

    // Reset during bit 4 of 8'hFF, then a clean 8'h5A
    fe0 = feCount;
    ov0 = ovCount;
    c = cyc + 1;
    for (int n = c + 2; n < c + 302; n++) busyMap[n] = 1'b1;
    rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      tick(BIT);
    end
    tick(HALF);
    reset = 1'b1;
    rx = 1'b1;
    for (int n = cyc; n < cyc + 400 && n < MAXC; n++) begin
      busyMap[n] = 1'b0;
      evKind[n]  = EV_NONE;
    end
    mValid = 1'b0;
    mData  = 8'h00;
    mBusy  = 1'b0;
    mFe    = 1'b0;
    mOv    = 1'b0;
    mPe    = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(5);
    sendFrame(8'h5A, 1'b0, 1'b1, 0, c);
    tick(3);
    chk("rst_rxData", 32'(rxData), 32'h5A);
    chk("rst_rxValid", 32'(rxValid), 32'd1);
    chk("rst_noflags", 32'((feCount - fe0) + (ovCount - ov0)), 32'd0);
    drain();
    tick(10);

`ifdef UART_RX_PARITY_EN
    // 8'h5A has even weight, so a parity bit of 1 is wrong
    pe0 = peCount;
    sendFrame(8'h5A, 1'b1, 1'b1, 0, c);
    tick(5);
    chk("par_pulse_count", 32'(peCount - pe0), 32'd1);
    chk("par_rxValid", 32'(rxValid), 32'd0);
    tick(10);
`else
    pe0 = peCount;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    repeat (MAXC - 16) @(posedge clk);
    miscompares++;
    $display("FAIL watchdog: got cycle %0d, expected completion before %0d", cyc, MAXC - 16);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- UART receive front end for soc32e; sits directly downstream of the top-level `rx` pin and feeds received bytes to the UART peripheral's register/bus side.
- Synchronises `rx`, detects and validates the start bit, and samples 8 data bits LSB-first at mid-bit.
- Checks the stop bit and presents each byte in a one-entry holding register with a valid/ready handshake.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- BIT_CYCLES, 868: clk cycles per bit (100 MHz / 115200); legal range 4..65535.
- HALF_CYCLES, BIT_CYCLES/2: cycles from start-bit falling edge to the start-bit mid-sample.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- rxData  output  8  received byte (holding register).
- rxValid  output  1  rxData holds an unconsumed byte.
- rxReady  input  1  consumer accepts rxData when rxValid && rxReady at posedge clk.
- frameError  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good byte completed while holding register full and not being drained.
- busy  output  1  receiver is not in IDLE.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-high on `reset`.
- Reset values:
  - Synchroniser flops = 1.
  - State = IDLE, bit counter = 0, cycle counter = 0, shift register = 0.
  - rxData = 8'h00, rxValid = 0, frameError = 0, overrun = 0, busy = 0.
- Synchroniser: two-flop sync of `rx` to `rxS`. All decisions use `rxS`; 2-cycle input latency.
- Cycle counter: 16-bit. Reloaded on every state entry; terminal count compares to HALF_CYCLES-1 or BIT_CYCLES-1.
- States:
  - IDLE: when rxS==0, go to START, counter=0.
  - START: at count HALF_CYCLES-1, sample rxS.
    - rxS==0: go to DATA, counter=0, bit=0.
    - rxS==1 (glitch): return to IDLE, no flags.
  - DATA: at count BIT_CYCLES-1, shift rxS into bit[7] with a right shift, so the first received bit lands in bit 0. Bit counter increments; after bit 7 go to STOP (or PARITY if enabled).
  - STOP: at count BIT_CYCLES-1, sample rxS.
    - rxS==1: deliver byte, go to IDLE.
    - rxS==0: pulse frameError, discard byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxS==1, then IDLE. This covers a break condition: no repeated start detection.
- Deliver rules, evaluated in the cycle after the stop-bit sample:
  - rxValid==0: rxData <= byte, rxValid <= 1.
  - rxValid==1 && rxReady==1 (simultaneous drain): rxData <= new byte, rxValid stays 1, no overrun.
  - rxValid==1 && rxReady==0: old byte kept, new byte dropped, overrun pulses 1 cycle.
- Handshake: rxValid clears the cycle after acceptance unless a new byte is loaded in that same cycle. rxData is stable while rxValid==1 && rxReady==0. rxReady while rxValid==0 is ignored.
- Latency: rx falling edge to rxValid rising = 2 + HALF_CYCLES + 9*BIT_CYCLES + 1 cycles (+BIT_CYCLES with parity).
- busy = (state != IDLE).
- Reset mid-frame: all state cleared immediately; any partial byte is lost; no flag pulses.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one bit at BIT_CYCLES-1.
  - Parity is even: the XOR of 8 data bits and the parity bit must be 0.
  - Adds output `parityError` (1 bit, reset 0). On mismatch it pulses 1 cycle when the stop bit is sampled and the byte is discarded. If the stop bit is also bad, frameError takes precedence and parityError is not pulsed.
- Undefined: no PARITY state, no parityError port; frame is 8N1.

Test Plan (BIT_CYCLES=16):
- Send 8'hA5 as 8N1, rxReady=0 → rxValid=1 and rxData=8'hA5, 2+8+144+1=155 cycles after the falling edge; frameError=0, overrun=0.
- rx low for 4 cycles then high in IDLE → START aborts at the mid-sample; busy returns to 0; rxValid stays 0; no flags.
- Send 8'h3C with the stop bit driven low, then hold rx low 40 cycles → frameError pulses exactly 1 cycle; rxValid stays 0; busy stays 1 until rx returns high.
- Send 8'h11 then 8'h22 back-to-back with rxReady=0 → rxData=8'h11; overrun pulses once when the second byte completes.
- Repeat the previous scenario with rxReady=1 asserted in the exact cycle the second byte delivers → rxData=8'h22, rxValid stays 1, no overrun.
- Assert reset during bit 4 of 8'hFF, release, then send 8'h5A → only 8'h5A is received; no flags. With UART_RX_PARITY_EN, send 8'h5A with parity=1 → parityError pulse, rxValid=0.
